// File: rtl/blinker_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
// Mode encoding matches the two-bit cfg_mode field of a config write.
package blinker_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Channel-select width; a single channel still needs a one-bit field.
    function automatic int ch_width(input int num_leds);
        return (num_leds > 1) ? $clog2(num_leds) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: stores mode/value, runs its own counter and drives a
// registered LED bit that follows the stored state one cycle later.
module led_channel
    import blinker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  mode_t            wr_mode,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             tick,
    output logic             led
);

    mode_t            mode_reg,  mode_next;
    logic [CNT_W-1:0] val_reg,   val_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             phase_reg, phase_next;
    logic             led_reg,   led_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg  <= MODE_OFF;
            val_reg   <= '0;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            led_reg   <= 1'b0;
        end else begin
            mode_reg  <= mode_next;
            val_reg   <= val_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            led_reg   <= led_next;
        end
    end

    always_comb begin
        mode_next  = mode_reg;
        val_next   = val_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        led_next   = 1'b0;

        // LED is derived from the state as it stood before this edge.
        case (mode_reg)
            MODE_ON:    led_next = 1'b1;
            MODE_BLINK: led_next = phase_reg;
            MODE_PWM:   led_next = (cnt_reg < val_reg);
            default:    led_next = 1'b0;
        endcase

        if (wr) begin
            // A write wins over a coincident tick: that tick is dropped.
            mode_next  = wr_mode;
            val_next   = wr_val;
            cnt_next   = '0;
            phase_next = 1'b0;
        end else begin
            case (mode_reg)
                MODE_BLINK: begin
                    if (tick) begin
                        if (cnt_reg == val_reg) begin
                            cnt_next   = '0;
                            phase_next = ~phase_reg;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                MODE_PWM: cnt_next = cnt_reg + 1'b1;
                default:  cnt_next = '0;
            endcase
        end
    end

    assign led = led_reg;

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel LED blinker: shared tick prescaler, config write decode with
// acknowledge pulse, and one led_channel per LED.
module multi_blinker
    import blinker_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 12000000,
    parameter int CNT_W    = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           cfg_we,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                     cfg_mode,
    input  logic [CNT_W-1:0]                               cfg_val,
    output logic                                           cfg_ack,
    output logic                                           tick,
    output logic [NUM_LEDS-1:0]                            led
);

    localparam int CH_W  = ch_width(NUM_LEDS);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    presc_reg;
    logic                tick_reg;
    logic                ack_reg;
    logic [NUM_LEDS-1:0] hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            presc_reg <= (presc_reg == PRE_LAST) ? '0 : presc_reg + 1'b1;
            tick_reg  <= (presc_reg == PRE_LAST);
            // Out-of-range channels match no decoder, so they are never acked.
            ack_reg   <= |hit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            assign hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            led_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr      (hit[gi]),
                .wr_mode (mode_t'(cfg_mode)),
                .wr_val  (cfg_val),
                .tick    (tick_reg),
                .led     (led[gi])
            );
        end
    endgenerate

    assign tick    = tick_reg;
    assign cfg_ack = ack_reg;

endmodule

// File: tb/tb_multi_blinker.sv
// Randomised self-checking bench for multi_blinker; expected LED values come
// from closed-form per-channel formulas over the log of accepted writes.
module tb_multi_blinker;

    localparam int NUM_LEDS = 3;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_val = '0;
    logic       cfg_ack;
    logic       tick;
    logic [2:0] led;

    always #5 clk = ~clk;

    multi_blinker #(
        .NUM_LEDS (NUM_LEDS),
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_val  (cfg_val),
        .cfg_ack  (cfg_ack),
        .tick     (tick),
        .led      (led)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;   // rising edges since reset release

    typedef struct {
        int e;
        int ch;
        int mode;
        int val;
    } wr_t;
    wr_t wq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // LED of channel ch as seen after edge n: it reflects the state after edge n-1.
    function automatic int exp_led(input int ch, input int n);
        int np, w, mode, val, t, idx;
        if (n <= 1) return 0;
        np  = n - 1;
        idx = -1;
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].ch == ch && wq[i].e <= np) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) return 0;
        w    = wq[idx].e;
        mode = wq[idx].mode;
        val  = wq[idx].val;
        case (mode)
            1: return 1;
            2: begin
                // ticks seen at edges m in (w, np], tick high before m iff (m-1)%TICK_DIV==0
                t = (np - 1) / TICK_DIV - (w - 1) / TICK_DIV;
                return (t / (val + 1)) % 2;
            end
            3: return (((np - w) % 256) < val) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_leds(input int n);
        int r = 0;
        for (int c = 0; c < NUM_LEDS; c++) r |= exp_led(c, n) << c;
        return r;
    endfunction

    task automatic step(input logic we, input int ch, input int mode, input int val);
        logic acc;
        cfg_we   = we;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_val  = 8'(val);
        acc      = we && (ch < NUM_LEDS);
        @(posedge clk);
        edge_n++;
        if (acc) begin
            wq.push_back('{edge_n, ch, mode, val});
            $display("write  edge %0d ch %0d mode %0d val %0d", edge_n, ch, mode, val);
        end else if (we) begin
            $display("reject edge %0d ch %0d mode %0d val %0d", edge_n, ch, mode, val);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk("tick", tick, (edge_n % TICK_DIV == 0) ? 1 : 0);
        chk("ack", cfg_ack, acc);
        chk("led", led, exp_leds(edge_n));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
    endtask

    task automatic rand_run(input int n);
        int ch, mode, val;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(5) == 0) begin
                ch   = $urandom_range(3);
                mode = $urandom_range(3);
                val  = (mode == 2) ? $urandom_range(3) : $urandom_range(255);
                step(1'b1, ch, mode, val);
            end else begin
                step(1'b0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        int cnt;
        int found;

        // held in reset for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_led", led, 0);
            chk("rst_tick", tick, 0);
            chk("rst_ack", cfg_ack, 0);
        end
        rst_n = 1'b1;
        idle(8);

        // ON write, then an out-of-range channel write
        step(1'b1, 1, 1, 0);
        idle(2);
        chk("on_led", led, 3'b010);
        step(1'b1, 3, 1, 0);
        idle(2);

        // BLINK with half-period of 3 ticks: 50% duty over 24 cycles
        step(1'b1, 0, 2, 2);
        idle(40);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 0, 0, 0);
            cnt += int'(led[0]);
        end
        chk("blink_duty", cnt, 12);

        // PWM duty 64/256, then duty 0
        step(1'b1, 2, 3, 64);
        idle(5);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 0, 0, 0);
            cnt += int'(led[2]);
        end
        chk("pwm_duty64", cnt, 64);
        step(1'b1, 2, 3, 0);
        idle(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 0, 0, 0);
            cnt += int'(led[2]);
        end
        chk("pwm_duty0", cnt, 0);

        // back-to-back writes, then a BLINK write landing on a tick
        step(1'b1, 0, 0, 0);
        step(1'b1, 1, 0, 0);
        step(1'b1, 2, 1, 0);
        for (int i = 0; i < 8 && (edge_n % TICK_DIV) != 0; i++) step(1'b0, 0, 0, 0);
        step(1'b1, 0, 2, 2);
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 0, 0, 0);
            if (led[0]) begin
                found = i;
                break;
            end
        end
        chk("tick_write_first_toggle", found, 13);

        rand_run(500);

        // asynchronous reset between edges while blinking
        step(1'b1, 0, 2, 0);
        step(1'b1, 1, 1, 0);
        idle(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", led, 0);
        chk("async_tick", tick, 0);
        chk("async_ack", cfg_ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_led", led, 0);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        wq.delete();
        idle(20);
        chk("post_rst_off", led, 0);

        rand_run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_blinker.md
MULTI_BLINKER -- requirements
Module: multi_blinker

Interface
REQ-001 Parameter NUM_LEDS, default 4: number of independent LED channels, legal range 1..16.
REQ-002 Parameter TICK_DIV, default 12000000: CLK cycles per blink tick, legal value >= 2.
REQ-003 Parameter CNT_W, default 8: width of per-channel period/duty value.
REQ-004 CLK  input  1  single system clock; all logic on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 CFG_WE  input  1  config write strobe, sampled on each CLK edge.
REQ-007 CFG_CH  input  max(1,$clog2(NUM_LEDS))  target channel of write.
REQ-008 CFG_MODE  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-009 CFG_VAL  input  CNT_W  BLINK half-period in ticks minus one, or PWM duty.
REQ-010 CFG_ACK  output  1  one-cycle pulse confirming an accepted write.
REQ-011 TICK  output  1  one-cycle pulse every TICK_DIV cycles.
REQ-012 LED  output  NUM_LEDS  registered LED drive, bit i = channel i.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; TICK SHALL be 1 exactly in the cycle after the prescaler reaches TICK_DIV-1.
REQ-014 Each channel SHALL hold mode, value and a CNT_W-bit counter.
REQ-015 Write accepted when CFG_WE=1 and CFG_CH<NUM_LEDS at edge k: mode/value stored, channel counter cleared, CFG_ACK=1 for the cycle after edge k.
REQ-016 Write with CFG_CH>=NUM_LEDS SHALL be ignored: no state change, CFG_ACK stays 0.
REQ-017 LED bit SHALL reflect the new mode from edge k+1 onward (one-cycle latency after accept).
REQ-018 OFF: LED bit 0; counter held at 0.
REQ-019 ON: LED bit 1; counter held at 0.
REQ-020 BLINK: on each TICK, if counter==VAL then counter<=0 and LED toggles, else counter increments; LED starts at 0 on entry; VAL=0 toggles every tick.
REQ-021 PWM: counter increments every CLK cycle, wrapping 2^CNT_W-1 -> 0; LED = (counter < VAL), giving VAL/2^CNT_W duty; VAL=0 never high.
REQ-022 Write to a channel coinciding with TICK SHALL take priority: counter cleared, that tick not counted for that channel.
REQ-023 Writes back-to-back on consecutive cycles SHALL all be accepted; each produces its own CFG_ACK pulse.
REQ-024 Channels SHALL be fully independent; a write to one channel SHALL not disturb another's counter or LED.

Reset
REQ-025 RST_N low SHALL immediately force LED=0, TICK=0, CFG_ACK=0, prescaler=0, all modes OFF, values 0, counters 0.
REQ-026 Reset asserted mid-operation SHALL abort all activity; after release, behaviour restarts from REQ-025 state and prescaler begins at 0 on the first edge with RST_N high.

Structure
REQ-027 Shared package blinker_pkg SHALL hold mode constants MODE_OFF/ON/BLINK/PWM and the 2-bit mode type.
REQ-028 One sub-module led_channel (mode, value, counter, LED bit) SHALL be instantiated NUM_LEDS times via generate; prescaler and CFG_ACK live in the top.

Verification (bench params NUM_LEDS=3, TICK_DIV=4, CNT_W=8)
REQ-029 Hold RST_N low 5 cycles -> LED=000, TICK=0; release -> TICK pulses every 4 cycles, first on cycle 4.
REQ-030 Write CH=1 MODE=ON -> CFG_ACK high 1 cycle, LED=010 from next cycle; CH=3 write -> no ACK, LED unchanged.
REQ-031 Write CH=0 MODE=BLINK VAL=2 -> LED[0] toggles every 3 ticks (12 cycles), 50% duty.
REQ-032 Write CH=2 MODE=PWM VAL=64 -> LED[2] high exactly 64 of every 256 cycles; rewrite VAL=0 -> LED[2] constant 0.
REQ-033 Write CH=0 BLINK in same cycle as TICK -> counter 0, tick ignored, first toggle after 3 further ticks.
REQ-034 Assert RST_N mid-blink between edges -> LED=000 at once; after release all channels OFF until rewritten.
